// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_pkg;

  localparam int DMEM_DATA_W      = 32;
  localparam int DMEM_MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Wait counter width; a zero-latency build still needs a 1-bit counter.
  function automatic int cnt_width(input int latency);
    return (latency > 0) ? $clog2(latency + 1) : 1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage to data-memory request/response bundle.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                   req_valid;
  logic                   req_write;
  logic [31:0]            req_addr;
  logic [DMEM_DATA_W-1:0] req_wdata;
  logic                   stall;
  logic                   rsp_valid;
  logic [DMEM_DATA_W-1:0] rsp_rdata;
  logic                   err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  stall, rsp_valid, rsp_rdata, err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output stall, rsp_valid, rsp_rdata, err
  );

endinterface

// File: rtl/dmem_responder_array.sv
// Word array: synchronous write, registered read-first read. Not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem [2**ADDR_W];

  // Write when enabled; read the addressed word every cycle (old data on a write).
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one request at a time, LATENCY wait
// cycles, stall to the hazard unit while busy, one-cycle rsp_valid pulse.
// Optional misalignment check: define DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  dmem_responder_if.slave bus
);

  localparam int              CNT_W    = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  dmem_state_t            state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [ADDR_W-1:0]      idx;
  logic                   misaligned;
  logic                   access;
  logic                   arr_we;
  logic                   load_done;
  logic [DMEM_DATA_W-1:0] arr_rdata;
  logic [DMEM_DATA_W-1:0] rdata_q;
  logic                   unused_addr_bits;

  assign idx              = bus.req_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = |bus.req_addr[1:0];
  assign bus.err    = (state == RESP) & misaligned;
`else
  assign misaligned = 1'b0;
  assign bus.err    = 1'b0;
`endif

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (idx),
    .wdata (bus.req_wdata),
    .rdata (arr_rdata)
  );

  // State, wait counter and held load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rdata_q <= bus.rsp_rdata;
    end
  end

  // Next state and counter; access marks the edge on which memory is touched.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    access   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            state_nx = RESP;
            access   = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!bus.req_valid) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx = RESP;
          access   = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stall, response pulse and memory controls; writes are blocked during reset.
  always_comb begin
    bus.stall     = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state)
      IDLE:    bus.stall     = bus.req_valid;
      WAIT:    bus.stall     = 1'b1;
      RESP:    bus.rsp_valid = 1'b1;
      default: bus.stall     = 1'b0;
    endcase
    arr_we    = access & bus.req_write & ~misaligned & rst;
    load_done = (state == RESP) & ~bus.req_write & ~misaligned;
  end

  // A completed load shows the fresh array word; otherwise the last load is held.
  assign bus.rsp_rdata = load_done ? arr_rdata : rdata_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Wait-state data-memory responder for the pipelined core's memory stage. It accepts one load/store request at a time from the M stage and completes it after a fixed number of wait cycles. While a request is in flight it drives a stall request to the hazard unit, which freezes the pipeline. It replaces the zero-latency data memory, so the pipeline can be exercised against realistic memory timing.

## Interface
- `ADDR_W`, default 10: word-address width; depth is 2^ADDR_W 32-bit words.
- `LATENCY`, default 2: number of wait cycles spent in WAIT; legal range 0..15.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: M-stage holds a load or store; stays stable while `stall`=1.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address from ALUResultM.
- `req_wdata` in 32: store data from WriteDataM.
- `stall` out 1: hold pipeline; feeds the hazard unit.
- `rsp_valid` out 1: one-cycle pulse marking completion.
- `rsp_rdata` out 32: load data; holds its value between loads.
- `err` out 1: misaligned-access flag, valid with `rsp_valid` (see Configuration).

## Operation
- FSM states are IDLE, WAIT and RESP. A down-counter `cnt` of width clog2(LATENCY+1) runs during WAIT.
- **IDLE:**
  - `req_valid`=0: stay in IDLE.
  - `req_valid`=1 and LATENCY>0: go to WAIT and load `cnt`=LATENCY-1.
  - `req_valid`=1 and LATENCY=0: go to RESP.
- **WAIT:**
  - `req_valid` dropped (flush): abort to IDLE; no write, no `rsp_valid`.
  - `cnt`=0: go to RESP and perform the access on this edge.
    - Load: capture `mem[idx]` into `rsp_rdata`.
    - Store: write `req_wdata` to `mem[idx]`; `rsp_rdata` is unchanged.
  - Otherwise: decrement `cnt`.
- **RESP:** `rsp_valid`=1 and `stall`=0, so the pipeline advances at the next edge. Always return to IDLE.
- The LATENCY=0 path from IDLE to RESP performs the access on the IDLE→RESP edge.
- **Stall output:** `stall` = (IDLE & `req_valid`) | WAIT. This is combinational from the state and `req_valid`.
- **Word index:** `idx` = `req_addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo the depth.
- **Request boundaries:**
  - Back-to-back requests: the new request is recognized in the IDLE cycle after RESP, with no extra bubble.
  - Requests are handled one at a time; there is never more than one outstanding request.
- **Memory array:** not reset. Contents survive `rst`.

## Timing
- Reset values: state = IDLE, `cnt` = 0, `rsp_rdata` = 0, `rsp_valid` = 0, `err` = 0. `stall` follows `req_valid`.
- Request accepted at cycle 0 (IDLE with `req_valid`=1):
  - `stall` is high for cycles 0..LATENCY (LATENCY+1 cycles).
  - `rsp_valid` is high in cycle LATENCY+1.
  - The pipeline advances at the end of cycle LATENCY+1.
- The store takes effect at the start of cycle LATENCY+1. A load in the next request sees the new value.
- Reset asserted in WAIT returns to IDLE immediately; the pending store is not performed.
- Reset asserted in RESP cancels `rsp_valid`; a store already committed remains.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- **Defined:** a request with `req_addr[1:0]` != 0 runs the normal timing, but:
  - the access is suppressed (no write; `rsp_rdata` is held);
  - `err`=1 during RESP.
- **Undefined:** `err` is tied to 0, `req_addr[1:0]` is ignored, and the access proceeds on the truncated word index.

## Structure
- `dmem_pkg` holds:
  - the state enum `dmem_state_t` (IDLE, WAIT, RESP);
  - the `DMEM_DATA_W`=32 constant;
  - the maximum-latency constant (15).
- Sub-module `dmem_array` is a synchronous-write, registered-read word array with ports `clk`, `we`, `addr`, `wdata`, `rdata`.
- The FSM, counter, stall logic and error logic stay in the top module.

## Test plan
- **Single load:** preload `mem[4]`=0xDEADBEEF; load at 0x10 with LATENCY=2 → `stall` high 3 cycles, then `rsp_valid` pulse with `rsp_rdata`=0xDEADBEEF.
- **Store then load:** store 0x12345678 to 0x20, then immediately load 0x20 → load returns 0x12345678, with no bubble between the requests.
- **Flush abort:** store to 0x30 with `req_valid` dropped in WAIT → no `rsp_valid`, and a later load of 0x30 returns the old value.
- **Reset mid-op:** assert `rst` during WAIT of a store → all outputs return to reset values; the stored word is unchanged.
- **Misalignment (macro on):** load 0x13 → `err`=1 with `rsp_valid` and `rsp_rdata` held. With the macro off, `err`=0 and the data comes from `mem[4]`.
- **LATENCY=0 and wrap:** `stall` is high exactly 1 cycle; a store to 0x1000 (ADDR_W=10) aliases to `mem[0]`.
